// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: address/data
// widths, wait-counter width and the arbiter FSM state encoding.
// The FORCE state only exists when RF_WB_STARVE_GUARD_EN is defined.
package rf_write_arbiter_pkg;

  localparam int unsigned RF_ADDR_W  = 5;
  localparam int unsigned RF_DATA_W  = 32;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef RF_WB_STARVE_GUARD_EN
    ST_FORCE = 2'd2,
`endif
    ST_HOLD  = 2'd1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_hold_reg.sv
// One-entry hold register for a secondary (long-latency unit) write that
// lost arbitration. Provides the valid/ready handshake toward the unit.
module rf_wb_hold_reg
  import rf_write_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 drain_i,
  input  logic                 clear_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  input  logic [RF_DATA_W-1:0] wdata_i,
  output logic                 valid_o,
  output logic [RF_ADDR_W-1:0] rd_o,
  output logic [RF_DATA_W-1:0] wdata_o,
  output logic                 ready_o
);

  logic                 valid_q, valid_d;
  logic [RF_ADDR_W-1:0] rd_q, rd_d;
  logic [RF_DATA_W-1:0] data_q, data_d;

  // Load wins over drain so a drain and refill in the same cycle keeps the entry full.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      data_d  = wdata_i;
    end else if (drain_i || clear_i) begin
      valid_d = 1'b0;
    end
  end

  // Hold entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign wdata_o = data_q;
  assign ready_o = !valid_q || drain_i;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage and a
// long-latency unit. Optional starvation guard (FORCE state + wait
// counter) is enabled by defining RF_WB_STARVE_GUARD_EN.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned RWE_SIZE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RF_ADDR_W-1:0] wb_inst_rd_in,
  input  logic [RWE_SIZE-1:0]  wb_regwrite_in,
  input  logic [RF_DATA_W-1:0] wb_rf_wdata_in,
  input  logic                 lu_valid,
  input  logic [RF_ADDR_W-1:0] lu_rd,
  input  logic [RF_DATA_W-1:0] lu_wdata,
  output logic                 lu_ready,
  output logic                 pl_stall,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [RWE_SIZE-1:0]  rf_we,
  output logic [RF_DATA_W-1:0] rf_wdata,
  output logic                 hold_valid,
  output logic [RF_ADDR_W-1:0] hold_rd
);

  if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("rf_write_arbiter: MAX_WAIT must be in 2..255");
  end

  arb_state_e           state_q, state_d;
  logic                 pl_req, lu_xfer, stale, drain;
  logic                 grant_pl, grant_sec, load, clear;
  logic [RF_DATA_W-1:0] hold_data;
  logic [RF_ADDR_W-1:0] sec_rd;
  logic [RF_DATA_W-1:0] sec_data;
  logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [RWE_SIZE-1:0]  rf_we_q, rf_we_d;
  logic [RF_DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  assign pl_req  = (wb_regwrite_in != '0) && (wb_inst_rd_in != '0);
  // An accepted transfer to r0 is consumed here and never reaches the hold or the RF.
  assign lu_xfer = lu_valid && lu_ready && (lu_rd != '0);
  assign stale   = hold_valid && pl_req && (wb_inst_rd_in == hold_rd);

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(MAX_WAIT - 2);
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pl_stall_q;

  // Held entry leaves through the write port: free HOLD cycle or FORCE.
  assign drain = hold_valid &&
                 (((state_q == ST_HOLD) && !pl_req) || (state_q == ST_FORCE));
`else
  assign drain = hold_valid && (state_q == ST_HOLD) && !pl_req;
`endif

  rf_wb_hold_reg u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .drain_i (drain),
    .clear_i (clear),
    .rd_i    (lu_rd),
    .wdata_i (lu_wdata),
    .valid_o (hold_valid),
    .rd_o    (hold_rd),
    .wdata_o (hold_data),
    .ready_o (lu_ready)
  );

  // Next-state, grant and hold-control decode.
  always_comb begin
    state_d   = state_q;
    grant_pl  = 1'b0;
    grant_sec = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    sec_rd    = hold_rd;
    sec_data  = hold_data;
`ifdef RF_WB_STARVE_GUARD_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pl_req) begin
          grant_pl = 1'b1;
          if (lu_xfer) begin
            load    = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (lu_xfer) begin
          grant_sec = 1'b1;
          sec_rd    = lu_rd;
          sec_data  = lu_wdata;
        end
      end
      ST_HOLD: begin
        if (pl_req) begin
          grant_pl = 1'b1;
          if (stale) begin
            clear   = 1'b1;
            state_d = ST_IDLE;
`ifdef RF_WB_STARVE_GUARD_EN
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_FORCE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
`endif
          end
        end else begin
          grant_sec = 1'b1;
`ifdef RF_WB_STARVE_GUARD_EN
          cnt_d     = '0;
`endif
          if (lu_xfer) load = 1'b1;
          else         state_d = ST_IDLE;
        end
      end
`ifdef RF_WB_STARVE_GUARD_EN
      // A transfer accepted while draining refills the hold, so return to HOLD instead of IDLE.
      ST_FORCE: begin
        grant_sec = 1'b1;
        if (lu_xfer) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_we_d    = '0;
    if (grant_pl) begin
      rf_waddr_d = wb_inst_rd_in;
      rf_wdata_d = wb_rf_wdata_in;
      rf_we_d    = wb_regwrite_in;
    end else if (grant_sec) begin
      rf_waddr_d = sec_rd;
      rf_wdata_d = sec_data;
      rf_we_d    = '1;
    end
  end

  // FSM state, wait counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rf_waddr_q <= '0;
      rf_we_q    <= '0;
      rf_wdata_q <= '0;
`ifdef RF_WB_STARVE_GUARD_EN
      cnt_q      <= '0;
      pl_stall_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rf_waddr_q <= rf_waddr_d;
      rf_we_q    <= rf_we_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef RF_WB_STARVE_GUARD_EN
      cnt_q      <= cnt_d;
      pl_stall_q <= (state_d == ST_FORCE);
`endif
    end
  end

`ifdef RF_WB_STARVE_GUARD_EN
  assign pl_stall = pl_stall_q;
`else
  assign pl_stall = 1'b0;
`endif
  assign rf_waddr = rf_waddr_q;
  assign rf_we    = rf_we_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus pushes expected RF writes
// (address, data, cycle) into a queue; a negedge monitor pops and compares.
// Starvation-guard tests follow RF_WB_STARVE_GUARD_EN.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_inst_rd_in;
  logic [0:0]  wb_regwrite_in;
  logic [31:0] wb_rf_wdata_in;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wdata;
  logic        lu_ready, pl_stall, hold_valid;
  logic [4:0]  rf_waddr, hold_rd;
  logic [0:0]  rf_we;
  logic [31:0] rf_wdata;

  rf_write_arbiter #(.MAX_WAIT(4), .RWE_SIZE(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_inst_rd_in  (wb_inst_rd_in),
    .wb_regwrite_in (wb_regwrite_in),
    .wb_rf_wdata_in (wb_rf_wdata_in),
    .lu_valid       (lu_valid),
    .lu_rd          (lu_rd),
    .lu_wdata       (lu_wdata),
    .lu_ready       (lu_ready),
    .pl_stall       (pl_stall),
    .rf_waddr       (rf_waddr),
    .rf_we          (rf_we),
    .rf_wdata       (rf_wdata),
    .hold_valid     (hold_valid),
    .hold_rd        (hold_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    wb_regwrite_in = pw;
    wb_inst_rd_in  = prd;
    wb_rf_wdata_in = pd;
    lu_valid       = lv;
    lu_rd          = lrd;
    lu_wdata       = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d, input int unsigned dly);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + dly;
    exp_q.push_back(e);
  endtask

  // Monitor: every RF write must match the oldest expected write and its cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rf_write_unexpected: got r%0d=0x%0h at cycle %0d, expected no write",
                   rf_waddr, rf_wdata, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rf_waddr !== e.addr || rf_wdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL rf_write: got r%0d=0x%0h at cycle %0d, expected r%0d=0x%0h at cycle %0d",
                     rf_waddr, rf_wdata, cyc, e.addr, e.data, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL rf_write_missing: got no write at cycle %0d, expected r%0d=0x%0h",
                 cyc, e.addr, e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"},      32'(rf_we),      32'd0);
    check({tag, "_rf_waddr"},   32'(rf_waddr),   32'd0);
    check({tag, "_rf_wdata"},   rf_wdata,        32'd0);
    check({tag, "_pl_stall"},   32'(pl_stall),   32'd0);
    check({tag, "_lu_ready"},   32'(lu_ready),   32'd1);
    check({tag, "_hold_valid"}, 32'(hold_valid), 32'd0);
    check({tag, "_hold_rd"},    32'(hold_rd),    32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Secondary only: granted directly, visible next cycle.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5);
    #1;
    check("direct_lu_ready", 32'(lu_ready), 32'd1);
    expw(5'd5, 32'hA5A5_A5A5, 1);
    step();
    check("direct_hold_valid", 32'(hold_valid), 32'd0);
    idle();
    step();

    // Collision: pipeline first, held write next cycle.
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    expw(5'd3, 32'h11, 1);
    expw(5'd7, 32'h22, 2);
    step();
    idle();
    check("collide_hold_valid", 32'(hold_valid), 32'd1);
    check("collide_hold_rd", 32'(hold_rd), 32'd7);
    step();
    check("collide_hold_clear", 32'(hold_valid), 32'd0);
    step();

    // Transfer to r0 is accepted and dropped.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_0000);
    #1;
    check("r0_lu_ready", 32'(lu_ready), 32'd1);
    step();
    idle();
    check("r0_hold_valid", 32'(hold_valid), 32'd0);
    step();

    // Stale suppression: younger pipeline write to the held rd wins.
    drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    expw(5'd2, 32'h1, 1);
    step();
    drive(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'd0);
    expw(5'd9, 32'h77, 1);
    step();
    idle();
    check("stale_hold_valid", 32'(hold_valid), 32'd0);
    repeat (2) step();

    // Drain and refill in the same cycle.
    drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd4, 32'hB);
    expw(5'd1, 32'hA, 1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hC);
    #1;
    check("refill_lu_ready", 32'(lu_ready), 32'd1);
    expw(5'd4, 32'hB, 1);
    step();
    idle();
    check("refill_hold_valid", 32'(hold_valid), 32'd1);
    check("refill_hold_rd", 32'(hold_rd), 32'd6);
    expw(5'd6, 32'hC, 1);
    step();
    check("refill_drained", 32'(hold_valid), 32'd0);
    step();

`ifdef RF_WB_STARVE_GUARD_EN
    // Starvation: MAX_WAIT=4 -> stall after 3 waiting cycles, r9 written in the stall cycle.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
    expw(5'd1, 32'h100, 1);
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      check("starve_no_stall", 32'(pl_stall), 32'd0);
      drive(1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b0, 5'd0, 32'd0);
      #1;
      check("starve_lu_ready", 32'(lu_ready), 32'd0);
      expw(5'(10 + i), 32'(32'h200 + i), 1);
      step();
    end
    check("starve_stall", 32'(pl_stall), 32'd1);
    drive(1'b1, 5'd13, 32'h300, 1'b0, 5'd0, 32'd0);
    expw(5'd9, 32'h99, 1);
    step();
    check("starve_stall_one_cycle", 32'(pl_stall), 32'd0);
    check("starve_hold_empty", 32'(hold_valid), 32'd0);
    expw(5'd13, 32'h300, 1);
    step();
    idle();
    step();

    // Reset while in FORCE: held write is discarded.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hBAD);
    expw(5'd1, 32'h1, 1);
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 32'(32'h400 + i), 1'b0, 5'd0, 32'd0);
      expw(5'(20 + i), 32'(32'h400 + i), 1);
      step();
    end
    check("force_entered", 32'(pl_stall), 32'd1);
`else
    // Without the guard, the held write waits until a free cycle.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
    expw(5'd1, 32'h100, 1);
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b0, 5'd0, 32'd0);
      expw(5'(10 + i), 32'(32'h200 + i), 1);
      step();
      check("noguard_no_stall", 32'(pl_stall), 32'd0);
      check("noguard_hold_valid", 32'(hold_valid), 32'd1);
    end
    idle();
    expw(5'd9, 32'h99, 1);
    step();
    check("noguard_drained", 32'(hold_valid), 32'd0);
    step();

    // Reset while in HOLD: held write is discarded.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hBAD);
    expw(5'd1, 32'h1, 1);
    step();
    drive(1'b1, 5'd20, 32'h400, 1'b0, 5'd0, 32'd0);
    expw(5'd20, 32'h400, 1);
    step();
`endif
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle();
    #1;
    check_reset_outputs("midreset");
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
